// File: rtl/pulse_voice.sv
// pulse_voice: square-wave voice with duty sequencer, volume envelope,
// length counter and a free-running frame pulse for downstream alignment.
// Ports: i_clk, i_rst (sync, active-high), i_load strobe + config
// (i_period, i_duty, i_volume, i_env_en, i_len, i_sweep_shift, i_sweep_neg),
// o_output (9-bit mixer compare), o_frame_pulse, o_active.
// Optional frequency sweep: define PULSE_VOICE_SWEEP_EN.
module pulse_voice #(
  parameter int TICK_DIV  = 28,
  parameter int FRAME_DIV = 104166
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [10:0] i_period,
  input  logic [1:0]  i_duty,
  input  logic [3:0]  i_volume,
  input  logic        i_env_en,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_sweep_shift,
  input  logic        i_sweep_neg,
  output logic [8:0]  o_output,
  output logic        o_frame_pulse,
  output logic        o_active
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [TW-1:0] presc_q, presc_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          fp_q, fp_d;
  logic [10:0]   timer_q, timer_d;
  logic [2:0]    step_q, step_d;
  logic [10:0]   period_q, period_d;
  logic [1:0]    duty_q, duty_d;
  logic [3:0]    vol_q, vol_d;
  logic          env_en_q, env_en_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    len_cnt_q, len_cnt_d;
  logic          active_q, active_d;
  logic [8:0]    out_q, out_d;

  logic          tick;
  logic          frame_wrap;
  logic [7:0]    pattern;
  logic          mute;

`ifdef PULSE_VOICE_SWEEP_EN
  logic [2:0]    sw_shift_q, sw_shift_d;
  logic          sw_neg_q, sw_neg_d;
  logic          sw_mute_q, sw_mute_d;
  logic [11:0]   sw_delta;
  logic [11:0]   sw_target;
`else
  logic          unused_sweep;
  assign unused_sweep = ^{i_sweep_shift, i_sweep_neg};
`endif

  // Bit n of the pattern is the level during step n.
  always_comb begin
    pattern = 8'b0000_0010;
    unique case (duty_q)
      2'd0: pattern = 8'b0000_0010;
      2'd1: pattern = 8'b0000_0110;
      2'd2: pattern = 8'b0001_1110;
      2'd3: pattern = 8'b1111_1001;
    endcase
  end

`ifdef PULSE_VOICE_SWEEP_EN
  always_comb begin
    sw_delta = {1'b0, period_q} >> sw_shift_q;
    if (sw_neg_q) sw_target = {1'b0, period_q} - sw_delta;
    else          sw_target = {1'b0, period_q} + sw_delta;
  end
  assign mute = (period_q < 11'd8) | sw_mute_q;
`else
  assign mute = (period_q < 11'd8);
`endif

  assign tick       = (presc_q == TW'(TICK_DIV - 1));
  assign frame_wrap = (frame_q == FW'(FRAME_DIV - 1));

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    frame_d   = frame_wrap ? '0 : frame_q + 1'b1;
    fp_d      = frame_wrap;
    timer_d   = timer_q;
    step_d    = step_q;
    period_d  = period_q;
    duty_d    = duty_q;
    vol_d     = vol_q;
    env_en_d  = env_en_q;
    len_d     = len_q;
    len_cnt_d = len_cnt_q;
    active_d  = active_q;
`ifdef PULSE_VOICE_SWEEP_EN
    sw_shift_d = sw_shift_q;
    sw_neg_d   = sw_neg_q;
    sw_mute_d  = sw_mute_q;
`endif

    if (i_load) begin
      // A load pre-empts any tick or frame event in the same cycle.
      period_d  = i_period;
      duty_d    = i_duty;
      env_en_d  = i_env_en;
      len_d     = i_len;
      timer_d   = i_period;
      step_d    = 3'd0;
      vol_d     = i_env_en ? 4'd15 : i_volume;
      len_cnt_d = i_len;
      active_d  = 1'b1;
`ifdef PULSE_VOICE_SWEEP_EN
      sw_shift_d = i_sweep_shift;
      sw_neg_d   = i_sweep_neg;
      sw_mute_d  = 1'b0;
`endif
    end else begin
      if (tick) begin
        if (timer_q == 11'd0) begin
          timer_d = period_q;
          step_d  = step_q + 3'd1;
        end else begin
          timer_d = timer_q - 11'd1;
        end
      end
      if (fp_q) begin
        if (env_en_q && (vol_q != 4'd0))
          vol_d = vol_q - 4'd1;
        if ((len_q != 8'd0) && active_q) begin
          len_cnt_d = len_cnt_q - 8'd1;
          if (len_cnt_q <= 8'd1) begin
            len_cnt_d = 8'd0;
            active_d  = 1'b0;
          end
        end
`ifdef PULSE_VOICE_SWEEP_EN
        if ((sw_shift_q != 3'd0) && !sw_mute_q) begin
          if (sw_target > 12'd2047) sw_mute_d = 1'b1;
          else                      period_d  = sw_target[10:0];
        end
`endif
      end
    end

    out_d = 9'd0;
    if (active_q && pattern[step_q] && !mute)
      out_d = {1'b0, vol_q, 4'b0000};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q   <= '0;
      frame_q   <= '0;
      fp_q      <= 1'b0;
      timer_q   <= 11'd0;
      step_q    <= 3'd0;
      period_q  <= 11'd0;
      duty_q    <= 2'd0;
      vol_q     <= 4'd0;
      env_en_q  <= 1'b0;
      len_q     <= 8'd0;
      len_cnt_q <= 8'd0;
      active_q  <= 1'b0;
      out_q     <= 9'd0;
    end else begin
      presc_q   <= presc_d;
      frame_q   <= frame_d;
      fp_q      <= fp_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      vol_q     <= vol_d;
      env_en_q  <= env_en_d;
      len_q     <= len_d;
      len_cnt_q <= len_cnt_d;
      active_q  <= active_d;
      out_q     <= out_d;
    end
  end

`ifdef PULSE_VOICE_SWEEP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_shift_q <= 3'd0;
      sw_neg_q   <= 1'b0;
      sw_mute_q  <= 1'b0;
    end else begin
      sw_shift_q <= sw_shift_d;
      sw_neg_q   <= sw_neg_d;
      sw_mute_q  <= sw_mute_d;
    end
  end
`endif

  assign o_output      = out_q;
  assign o_frame_pulse = fp_q;
  assign o_active      = active_q;

endmodule

// File: tb/tb_pulse_voice.sv
// tb_pulse_voice: directed bench for pulse_voice with TICK_DIV=28 and
// FRAME_DIV=100; expected values hand-computed from the step/frame timing.
module tb_pulse_voice;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [10:0] period;
  logic [1:0]  duty;
  logic [3:0]  volume;
  logic        env_en;
  logic [7:0]  len;
  logic [2:0]  sw_shift;
  logic        sw_neg;
  logic [8:0]  out;
  logic        fp;
  logic        active;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pulse_voice #(
    .TICK_DIV  (28),
    .FRAME_DIV (100)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_load        (load),
    .i_period      (period),
    .i_duty        (duty),
    .i_volume      (volume),
    .i_env_en      (env_en),
    .i_len         (len),
    .i_sweep_shift (sw_shift),
    .i_sweep_neg   (sw_neg),
    .o_output      (out),
    .o_frame_pulse (fp),
    .o_active      (active)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [10:0] p, input logic [1:0] d,
                         input logic [3:0] v, input logic e,
                         input logic [7:0] l);
    period = p;
    duty   = d;
    volume = v;
    env_en = e;
    len    = l;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_fp();
    int k;
    k = 0;
    @(negedge clk);
    while (!fp && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("fp_seen", {31'd0, fp}, 32'd1);
  endtask

  task automatic measure(input string tag, input logic [1:0] d,
                         input logic [10:0] p, input int hi, input int lo);
    int n;
    do_load(p, d, 4'd15, 1'b0, 8'd0);
    cyc(2);
    n = 0;
    while (out !== 9'd0 && n < 20000) begin @(negedge clk); n++; end
    n = 0;
    while (out !== 9'd240 && n < 20000) begin @(negedge clk); n++; end
    check({tag, "_start"}, {23'd0, out}, 32'd240);
    n = 0;
    while (out === 9'd240 && n < 40000) begin @(negedge clk); n++; end
    check({tag, "_hi"}, n, hi);
    n = 0;
    while (out === 9'd0 && n < 40000) begin @(negedge clk); n++; end
    check({tag, "_lo"}, n, lo);
  endtask

  initial begin
    bit bad;
    rst = 1'b1; load = 1'b0; period = '0; duty = '0; volume = '0;
    env_en = 1'b0; len = '0; sw_shift = '0; sw_neg = 1'b0;
    cyc(3);
    rst = 1'b0;
    check("rst_out", {23'd0, out}, 32'd0);
    check("rst_act", {31'd0, active}, 32'd0);
    check("rst_fp", {31'd0, fp}, 32'd0);

    // Envelope: 240 after load, then -16 per frame, saturating at 0.
    wait_fp();
    cyc(10);
    do_load(11'd100, 2'd3, 4'd0, 1'b1, 8'd0);
    cyc(1);
    check("env_start", {23'd0, out}, 32'd240);
    for (int k = 1; k <= 17; k++) begin
      wait_fp();
      cyc(2);
      check("env_lvl", {23'd0, out}, (k >= 15) ? 32'd0 : 32'((15 - k) * 16));
    end

    // Length 3: active drops on the third frame pulse.
    wait_fp();
    cyc(10);
    do_load(11'd100, 2'd3, 4'd9, 1'b0, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      wait_fp();
      cyc(1);
      check("len_act", {31'd0, active}, (k < 3) ? 32'd1 : 32'd0);
      cyc(1);
      check("len_out", {23'd0, out}, (k < 3) ? 32'd144 : 32'd0);
    end
    do_load(11'd100, 2'd3, 4'd9, 1'b0, 8'd0);
    cyc(1);
    check("reload_out", {23'd0, out}, 32'd144);
    check("reload_act", {31'd0, active}, 32'd1);

    // Mute: P<8 silences output while the note is active.
    do_load(11'd7, 2'd3, 4'd15, 1'b0, 8'd0);
    cyc(2);
    check("mute_out", {23'd0, out}, 32'd0);
    check("mute_act", {31'd0, active}, 32'd1);

    // Load coincident with the frame pulse: no decrement of vol or len.
    wait_fp();
    do_load(11'd100, 2'd3, 4'd0, 1'b1, 8'd5);
    cyc(1);
    check("coll_vol", {23'd0, out}, 32'd240);
    for (int k = 1; k <= 5; k++) begin
      wait_fp();
      cyc(1);
      check("coll_act", {31'd0, active}, (k < 5) ? 32'd1 : 32'd0);
    end

    // Reset mid-note silences the voice until the next load.
    do_load(11'd100, 2'd3, 4'd15, 1'b0, 8'd0);
    cyc(5);
    check("pre_rst_out", {23'd0, out}, 32'd240);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("mrst_out", {23'd0, out}, 32'd0);
    check("mrst_act", {31'd0, active}, 32'd0);
    check("mrst_fp", {31'd0, fp}, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out !== 9'd0 || active !== 1'b0) bad = 1'b1;
    end
    check("silent", {31'd0, bad}, 32'd0);

    // Duty patterns; step = 28*(P+1) clocks.
    measure("d0", 2'd0, 11'd8, 252, 1764);
    measure("d1", 2'd1, 11'd8, 504, 1512);
    measure("d3", 2'd3, 11'd8, 1512, 504);
    measure("tone", 2'd2, 11'd253, 28448, 28448);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
